// File: rtl/decoder_rr_arbiter_if.sv
// ============================================================================
//  Module   : decoder_rr_arbiter_if
//  Purpose  : Bundles the request vector and the decoder-select / grant
//             outputs of decoder_rr_arbiter into one interface.
//  Signals  : req        - request vector, bit i = requester i wants the decoder
//             sel_a/b/c  - decoder select inputs (grant index bits 2/1/0)
//             gnt_valid  - a grant is active this cycle
//             gnt_onehot - one-hot grant mirroring the decoder output
//             gnt_change - pulse on the first cycle of each new grant
//  Modports : master - requester side (drives req)
//             slave  - arbiter side (drives selects and grant outputs)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       sel_a;
  logic       sel_b;
  logic       sel_c;
  logic       gnt_valid;
  logic [7:0] gnt_onehot;
  logic       gnt_change;

  modport master (
    output req,
    input  sel_a, sel_b, sel_c, gnt_valid, gnt_onehot, gnt_change
  );

  modport slave (
    input  req,
    output sel_a, sel_b, sel_c, gnt_valid, gnt_onehot, gnt_change
  );
endinterface

`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
// ============================================================================
//  Module   : decoder_rr_arbiter
//  Purpose  : Round-robin arbiter sharing a 3-to-8 decoder among 8 requesters.
//             The granted index drives the decoder selects; a registered
//             one-hot grant mirrors the decoder output. Ownership changes
//             always pass through a one-cycle GAP (no grant) so the decoder
//             never switches directly from one line to another.
//  Ports    : sys_clk    - clock, rising edge
//             sys_rst_n  - asynchronous active-low reset
//             bus        - decoder_rr_arbiter_if.slave (req in; sel_a/b/c,
//                          gnt_valid, gnt_onehot, gnt_change out, all
//                          registered)
//  Params   : MAX_HOLD   - max consecutive grant cycles while others wait
//                          (2..31, only with ARB_HOLD_LIMIT_EN)
//             CNT_W      - hold-counter width, 2**CNT_W > MAX_HOLD
//  Options  : `define ARB_HOLD_LIMIT_EN to enable forced release after
//             MAX_HOLD cycles when another requester is waiting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  // Reject parameter sets the hold counter cannot represent.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 31) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_bad_params
    $error("decoder_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;            // current/previous owner, drives selects
  logic [2:0] last_idx, last_idx_nxt;  // round-robin pointer
  logic       valid_q, valid_nxt;
  logic [7:0] onehot_q, onehot_nxt;
  logic       change_q, change_nxt;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;
  logic       force_rel;

  // Search upward from last_idx+1; the 3-bit add wraps 7->0, and the final
  // candidate (k=8) is last_idx itself, giving it the lowest priority.
  always_comb begin
    winner = last_idx;
    found  = 1'b0;
    cand   = last_idx;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx + 3'(k);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             others_waiting;

  assign others_waiting = |(bus.req & ~(8'd1 << idx));
  assign force_rel      = (hold_cnt == CNT_W'(MAX_HOLD - 1)) && others_waiting;

  // Counts cycles spent in GRANT after the first; cleared on any exit from
  // GRANT so each new owner starts at zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt <= '0;
    end else if ((state == GRANT) && (state_nxt == GRANT)) begin
      if (hold_cnt != {CNT_W{1'b1}}) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    last_idx_nxt = last_idx;
    valid_nxt    = 1'b0;
    onehot_nxt   = 8'd0;
    change_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          idx_nxt      = winner;
          last_idx_nxt = winner;
          valid_nxt    = 1'b1;
          onehot_nxt   = 8'd1 << winner;
          change_nxt   = 1'b1;
        end
      end
      GRANT: begin
        // Owner release has priority over any other activity on req.
        if (!bus.req[idx] || force_rel) begin
          state_nxt = GAP;
        end else begin
          valid_nxt  = 1'b1;
          onehot_nxt = 8'd1 << idx;
        end
      end
      GAP: begin
        // Selects keep the old index (idx unchanged) so the decoder inputs
        // stay quiet while no grant is active.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      last_idx <= 3'd7;
      valid_q  <= 1'b0;
      onehot_q <= 8'd0;
      change_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      last_idx <= last_idx_nxt;
      valid_q  <= valid_nxt;
      onehot_q <= onehot_nxt;
      change_q <= change_nxt;
    end
  end

  assign bus.sel_a      = idx[2];
  assign bus.sel_b      = idx[1];
  assign bus.sel_c      = idx[0];
  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.gnt_change = change_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
// ============================================================================
//  Module   : tb_decoder_rr_arbiter
//  Purpose  : Self-checking bench for decoder_rr_arbiter. Expected grant
//             indices are queued when stimulus is applied and popped by a
//             monitor on every gnt_change pulse; scenario tasks check timing,
//             hold behaviour and reset inline.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_rr_arbiter;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   sb[$];

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] sel_w;
  assign sel_w = {bus.sel_a, bus.sel_b, bus.sel_c};

  // Scoreboard monitor plus one-hot / pulse invariants.
  always @(negedge clk) begin
    logic [7:0] exp_oh;
    int         exp_idx;
    if (rst_n) begin
      exp_oh = bus.gnt_valid ? (8'd1 << sel_w) : 8'd0;
      compared++;
      if (bus.gnt_onehot !== exp_oh) begin
        mismatched++;
        $display("FAIL onehot_invariant: got %h expected %h (valid=%b)", bus.gnt_onehot, exp_oh, bus.gnt_valid);
      end
      if (bus.gnt_change) begin
        compared++;
        if (!bus.gnt_valid) begin
          mismatched++;
          $display("FAIL change_without_valid: gnt_change=1 with gnt_valid=%b", bus.gnt_valid);
        end else if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected_grant: got index %0d expected no new grant", sel_w);
        end else begin
          exp_idx = sb.pop_front();
          if (sel_w !== 3'(exp_idx)) begin
            mismatched++;
            $display("FAIL sb_grant_order: got index %0d expected %0d", sel_w, exp_idx);
          end
        end
      end
    end
  end

  // Counts negedges until gnt_change is seen; -1 if the bound expires.
  task automatic wait_change(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.gnt_change) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic settle();
    bus.req = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({sel_w, bus.gnt_valid, bus.gnt_onehot, bus.gnt_change} !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got sel=%0d valid=%b onehot=%h change=%b expected all zero",
               sel_w, bus.gnt_valid, bus.gnt_onehot, bus.gnt_change);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(0);
    @(negedge clk);
    compared++;
    if (bus.gnt_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_no_early_grant: got valid=%b expected 0", bus.gnt_valid);
    end
    @(negedge clk);
    compared++;
    if ({sel_w, bus.gnt_valid, bus.gnt_onehot, bus.gnt_change} !== {3'b000, 1'b1, 8'h01, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_first_grant: got sel=%0d valid=%b onehot=%h change=%b expected sel=0 valid=1 onehot=01 change=1",
               sel_w, bus.gnt_valid, bus.gnt_onehot, bus.gnt_change);
    end
    settle();
  endtask

  task automatic test_rotation();
    int         n;
    logic [2:0] owner;
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int g = 0; g < 8; g++) sb.push_back(g);
    sb.push_back(0);
    wait_change(n);
    compared++;
    if (n != 2) begin
      mismatched++;
      $display("FAIL rotation_first_latency: got %0d expected 2", n);
    end
    for (int g = 0; g < 8; g++) begin
      owner = sel_w;
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.req[owner] = 1'b0;
      @(negedge clk);
      compared++;
      if (!(bus.gnt_valid === 1'b1 && sel_w === owner && bus.gnt_change === 1'b0)) begin
        mismatched++;
        $display("FAIL rotation_hold3: owner %0d got valid=%b sel=%0d expected valid=1 sel=%0d",
                 owner, bus.gnt_valid, sel_w, owner);
      end
      wait_change(n);
      compared++;
      if (n != 3) begin
        mismatched++;
        $display("FAIL rotation_gap: after owner %0d got %0d cycles to next grant expected 3", owner, n);
      end
      bus.req = 8'hFF;
    end
    settle();
  endtask

  task automatic test_sparse_wrap();
    int n;
    bus.req = 8'h40;
    sb.push_back(6);
    wait_change(n);
    compared++;
    if (n != 2) begin
      mismatched++;
      $display("FAIL sparse_setup_latency: got %0d expected 2", n);
    end
    settle();
    bus.req = 8'h05;
    sb.push_back(0);
    sb.push_back(2);
    sb.push_back(3);
    wait_change(n);
    compared++;
    if ({n, sel_w, bus.gnt_onehot} !== {32'd2, 3'b000, 8'h01}) begin
      mismatched++;
      $display("FAIL sparse_wrap_grant0: got n=%0d sel=%0d onehot=%h expected n=2 sel=0 onehot=01",
               n, sel_w, bus.gnt_onehot);
    end
    bus.req = 8'h04;
    wait_change(n);
    compared++;
    if ({n, bus.gnt_onehot} !== {32'd3, 8'h04}) begin
      mismatched++;
      $display("FAIL sparse_grant2: got n=%0d onehot=%h expected n=3 onehot=04", n, bus.gnt_onehot);
    end
    // Owner drops while another requester rises in the same cycle.
    bus.req = 8'h08;
    wait_change(n);
    compared++;
    if ({n, bus.gnt_onehot} !== {32'd3, 8'h08}) begin
      mismatched++;
      $display("FAIL drop_and_raise: got n=%0d onehot=%h expected n=3 onehot=08", n, bus.gnt_onehot);
    end
    settle();
  endtask

  task automatic test_hold_limit();
    int n;
    int hold;
    bus.req = 8'h03;
    sb.push_back(0);
`ifdef ARB_HOLD_LIMIT_EN
    sb.push_back(1);
`endif
    wait_change(n);
    hold = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.gnt_valid && sel_w == 3'd0 && !bus.gnt_change) hold++;
      else break;
    end
`ifdef ARB_HOLD_LIMIT_EN
    compared++;
    if (hold != 16) begin
      mismatched++;
      $display("FAIL hold_limit_cycles: got %0d expected 16", hold);
    end
    wait_change(n);
    compared++;
    if ({n, sel_w} !== {32'd2, 3'd1}) begin
      mismatched++;
      $display("FAIL hold_limit_next_owner: got n=%0d sel=%0d expected n=2 sel=1", n, sel_w);
    end
`else
    compared++;
    if (hold != 41) begin
      mismatched++;
      $display("FAIL no_hold_limit_cycles: got %0d expected 41", hold);
    end
`endif
    settle();
  endtask

  task automatic test_lone_holder();
    int n;
    int bad;
    bus.req = 8'h10;
    sb.push_back(4);
    wait_change(n);
    compared++;
    if ({n, bus.gnt_onehot} !== {32'd2, 8'h10}) begin
      mismatched++;
      $display("FAIL lone_first: got n=%0d onehot=%h expected n=2 onehot=10", n, bus.gnt_onehot);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(bus.gnt_valid === 1'b1 && bus.gnt_onehot === 8'h10 && bus.gnt_change === 1'b0)) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL lone_holder_steady: got %0d disturbed cycles expected 0", bad);
    end
    settle();
  endtask

  task automatic test_async_reset();
    int n;
    bus.req = 8'h20;
    sb.push_back(5);
    wait_change(n);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({sel_w, bus.gnt_valid, bus.gnt_onehot, bus.gnt_change} !== 13'd0) begin
      mismatched++;
      $display("FAIL async_reset_clear: got sel=%0d valid=%b onehot=%h change=%b expected all zero",
               sel_w, bus.gnt_valid, bus.gnt_onehot, bus.gnt_change);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(5);
    wait_change(n);
    compared++;
    if ({n, sel_w, bus.gnt_onehot} !== {32'd2, 3'd5, 8'h20}) begin
      mismatched++;
      $display("FAIL async_reset_regrant: got n=%0d sel=%0d onehot=%h expected n=2 sel=5 onehot=20",
               n, sel_w, bus.gnt_onehot);
    end
    settle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_hold_limit();
    test_lone_holder();
    test_async_reset();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: got %0d pending grants expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
